// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Quotient reported for a zero divisor; the top replicates this bit to WIDTH.
  localparam logic [DIV_WIDTH_DEFAULT-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: ripple-carry trial subtraction of the divisor.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   shifted,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   b_inv;
  logic [WIDTH-1:0] diff;
  logic [WIDTH+1:0] carry;

  // shifted + ~{0,divisor} + 1; carry out of the top bit means no borrow
  always_comb begin
    b_inv    = ~{1'b0, divisor};
    carry    = '0;
    diff     = '0;
    carry[0] = 1'b1;
    for (int i = 0; i <= int'(WIDTH); i++) begin
      if (i < int'(WIDTH)) begin
        diff[i] = shifted[i] ^ b_inv[i] ^ carry[i];
      end
      carry[i+1] = (shifted[i] & b_inv[i]) | (carry[i] & (shifted[i] ^ b_inv[i]));
    end
    q_bit    = carry[WIDTH+1];
    rem_next = q_bit ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div32_seq.sv
// Sequential restoring divider, one quotient bit per clock, valid/ready on both sides.
// Signed (two's-complement) operation is built only when DIV32_SIGNED_EN is defined.
module div32_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_next;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dvz_q;
  logic             accept, last_step;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] step_rem, q_new, quo_fix, rem_fix;
  logic             step_bit;

  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign last_step = (cnt_q == LAST_STEP);

`ifdef DIV32_SIGNED_EN
  logic neg_quo_q, neg_rem_q;

  // Magnitudes at accept; the most-negative value maps onto itself, which is its true magnitude
  assign a_neg   = is_signed & dividend[WIDTH-1];
  assign b_neg   = is_signed & divisor[WIDTH-1];
  assign a_mag   = a_neg ? (~dividend + WIDTH'(1)) : dividend;
  assign b_mag   = b_neg ? (~divisor + WIDTH'(1)) : divisor;
  assign quo_fix = neg_quo_q ? (~q_new + WIDTH'(1)) : q_new;
  assign rem_fix = neg_rem_q ? (~step_rem + WIDTH'(1)) : step_rem;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (accept) begin
      neg_quo_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
    end
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign a_neg   = 1'b0;
  assign b_neg   = 1'b0;
  assign a_mag   = dividend;
  assign b_mag   = divisor;
  assign quo_fix = q_new;
  assign rem_fix = step_rem;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .shifted  ({rem_q, quo_q[WIDTH-1]}),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .q_bit    (step_bit)
  );

  assign q_new = {quo_q[WIDTH-2:0], step_bit};

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_next;
  end

  // A zero divisor still spends one RUN cycle so its results register on the next edge
  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (dvz_q || last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      dvz_q       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            rem_q <= '0;
            cnt_q <= '0;
            dvs_q <= b_mag;
            dvz_q <= (divisor == '0);
            // raw dividend kept for the zero-divisor remainder
            quo_q <= (divisor == '0) ? dividend : a_mag;
          end
        end
        RUN: begin
          if (dvz_q) begin
            quotient    <= {WIDTH{DIV_ZERO_QUOTIENT[0]}};
            remainder   <= quo_q;
            div_by_zero <= 1'b1;
          end else begin
            rem_q <= step_rem;
            quo_q <= q_new;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_step) begin
              quotient    <= quo_fix;
              remainder   <= rem_fix;
              div_by_zero <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: scoreboard of expected results, one task per scenario.
module tb_div32_seq;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         is_signed;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int   n_cmp = 0;
  int   n_err = 0;
  res_t sb[$];

  div32_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: magnitude division with truncation toward zero, remainder follows dividend sign
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    res_t         res;
    logic         an, bn;
    logic [W-1:0] ma, mb, mq, mr;
`ifndef DIV32_SIGNED_EN
    s = 1'b0;
`endif
    if (b == '0) begin
      res.q   = '1;
      res.r   = a;
      res.dbz = 1'b1;
      return res;
    end
    an = s & a[W-1];
    bn = s & b[W-1];
    ma = an ? -a : a;
    mb = bn ? -b : b;
    mq = ma / mb;
    mr = ma % mb;
    res.q   = (an ^ bn) ? -mq : mq;
    res.r   = an ? -mr : mr;
    res.dbz = 1'b0;
    return res;
  endfunction

  // Issue one op, check latency, optional backpressure, then pop and compare the result
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int exp_lat, input int hold);
    int   lat;
    bit   got;
    res_t snap, exp;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL in_ready_before_op: got %b want 1", in_ready);
    end
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_valid  = 1'b1;
    @(posedge clk);
    sb.push_back(model(a, b, s));
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL out_valid_timeout: a=%h b=%h waited %0d cycles", a, b, lat);
      void'(sb.pop_front());
      return;
    end
    if (exp_lat > 0) begin
      n_cmp++;
      if (lat !== exp_lat) begin
        n_err++;
        $display("FAIL latency: a=%h b=%h got %0d want %0d", a, b, lat, exp_lat);
      end
    end
    snap = '{quotient, remainder, div_by_zero};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          {quotient, remainder, div_by_zero} !== snap) begin
        n_err++;
        $display("FAIL hold_cycle_%0d: ov=%b ir=%b q=%h r=%h z=%b want ov=1 ir=0 q=%h r=%h z=%b",
                 i, out_valid, in_ready, quotient, remainder, div_by_zero,
                 snap.q, snap.r, snap.dbz);
      end
    end
    out_ready = 1'b1;
    exp = sb.pop_front();
    n_cmp++;
    if (quotient !== exp.q) begin
      n_err++;
      $display("FAIL quotient: a=%h b=%h s=%b got %h want %h", a, b, s, quotient, exp.q);
    end
    n_cmp++;
    if (remainder !== exp.r) begin
      n_err++;
      $display("FAIL remainder: a=%h b=%h s=%b got %h want %h", a, b, s, remainder, exp.r);
    end
    n_cmp++;
    if (div_by_zero !== exp.dbz) begin
      n_err++;
      $display("FAIL div_by_zero: a=%h b=%h got %b want %b", a, b, div_by_zero, exp.dbz);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL return_to_idle: ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || quotient !== '0 ||
        remainder !== '0 || div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: ir=%b ov=%b q=%h r=%h z=%b want all 0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL in_ready_after_reset: got %b want 1", in_ready);
    end
  endtask

  task automatic test_unsigned();
    run_op(32'd100, 32'd7, 1'b0, W, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, W, 0);
    run_op(32'd5, 32'd9, 1'b0, W, 0);
    for (int i = 0; i < 6; i++) run_op($urandom, $urandom, 1'b0, W, 0);
    run_op($urandom, 32'($urandom_range(1, 255)), 1'b0, W, 0);
  endtask

  task automatic test_div_zero();
    run_op(32'h0000_1234, 32'd0, 1'b0, 1, 0);
    run_op(32'h8000_0000, 32'd0, 1'b1, 1, 0);
  endtask

  task automatic test_signed();
`ifdef DIV32_SIGNED_EN
    run_op(-32'sd7, 32'd2, 1'b1, W, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, W, 0);
    run_op(32'd7, -32'sd2, 1'b1, W, 0);
    for (int i = 0; i < 4; i++) run_op($urandom, $urandom, 1'b1, W, 0);
`else
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, W, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, W, 0);
`endif
  endtask

  task automatic test_backpressure();
    run_op(32'd1000, 32'd33, 1'b0, W, 5);
    run_op(32'd77, 32'd0, 1'b0, 1, 3);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) run_op($urandom, 32'($urandom_range(1, 1000)), 1'b0, W, 0);
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    dividend  = 32'd123456;
    divisor   = 32'd11;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_run_reset_hold: ir=%b ov=%b want 0 0", in_ready, out_valid);
    end
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < W + 5; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL abandoned_op: out_valid_seen=%b ir=%b want 0 1", seen, in_ready);
    end
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, W, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    is_signed = 1'b0;
    @(negedge clk);
    test_reset();
    test_unsigned();
    test_div_zero();
    test_signed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
